// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: two AXI4-Lite masters (M0 fetch, M1 data/host) share one
// slave port. Reads and writes have independent transaction-locked round-robin
// arbiters. READY/VALID and payload pass combinationally between owner and slave.
module axil_arbiter_2to1 #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // master 0
  input  logic [AXI_AWIDTH-1:0]     M0_AWADDR,
  input  logic [2:0]                M0_AWPROT,
  input  logic                      M0_AWVALID,
  output logic                      M0_AWREADY,
  input  logic [AXI_DWIDTH-1:0]     M0_WDATA,
  input  logic [AXI_DWIDTH/8-1:0]   M0_WSTRB,
  input  logic                      M0_WVALID,
  output logic                      M0_WREADY,
  output logic [1:0]                M0_BRESP,
  output logic                      M0_BVALID,
  input  logic                      M0_BREADY,
  input  logic [AXI_AWIDTH-1:0]     M0_ARADDR,
  input  logic [2:0]                M0_ARPROT,
  input  logic                      M0_ARVALID,
  output logic                      M0_ARREADY,
  output logic [AXI_DWIDTH-1:0]     M0_RDATA,
  output logic [1:0]                M0_RRESP,
  output logic                      M0_RVALID,
  input  logic                      M0_RREADY,
  // master 1
  input  logic [AXI_AWIDTH-1:0]     M1_AWADDR,
  input  logic [2:0]                M1_AWPROT,
  input  logic                      M1_AWVALID,
  output logic                      M1_AWREADY,
  input  logic [AXI_DWIDTH-1:0]     M1_WDATA,
  input  logic [AXI_DWIDTH/8-1:0]   M1_WSTRB,
  input  logic                      M1_WVALID,
  output logic                      M1_WREADY,
  output logic [1:0]                M1_BRESP,
  output logic                      M1_BVALID,
  input  logic                      M1_BREADY,
  input  logic [AXI_AWIDTH-1:0]     M1_ARADDR,
  input  logic [2:0]                M1_ARPROT,
  input  logic                      M1_ARVALID,
  output logic                      M1_ARREADY,
  output logic [AXI_DWIDTH-1:0]     M1_RDATA,
  output logic [1:0]                M1_RRESP,
  output logic                      M1_RVALID,
  input  logic                      M1_RREADY,
  // slave side
  output logic [AXI_AWIDTH-1:0]     S_AWADDR,
  output logic [2:0]                S_AWPROT,
  output logic                      S_AWVALID,
  input  logic                      S_AWREADY,
  output logic [AXI_DWIDTH-1:0]     S_WDATA,
  output logic [AXI_DWIDTH/8-1:0]   S_WSTRB,
  output logic                      S_WVALID,
  input  logic                      S_WREADY,
  input  logic [1:0]                S_BRESP,
  input  logic                      S_BVALID,
  output logic                      S_BREADY,
  output logic [AXI_AWIDTH-1:0]     S_ARADDR,
  output logic [2:0]                S_ARPROT,
  output logic                      S_ARVALID,
  input  logic                      S_ARREADY,
  input  logic [AXI_DWIDTH-1:0]     S_RDATA,
  input  logic [1:0]                S_RRESP,
  input  logic                      S_RVALID,
  output logic                      S_RREADY,
  // grants
  output logic [1:0]                RD_GNT,
  output logic [1:0]                WR_GNT
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;

  rd_state_t rd_state_r;
  wr_state_t wr_state_r;
  logic      rd_owner_r, rd_last_r, wr_owner_r, wr_last_r;
  logic      aw_done_r, w_done_r;
  logic [1:0] rd_gnt_r, wr_gnt_r;
  logic [1:0] rd_req_s, wr_req_s;
  logic      ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

  // Round-robin pick: a lone requester wins; on a tie the master not served last wins.
  function automatic logic pick_owner(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  function automatic logic [1:0] onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  assign rd_req_s = {M1_ARVALID, M0_ARVALID};
  assign wr_req_s = {M1_AWVALID | M1_WVALID, M0_AWVALID | M0_WVALID};
  assign ar_hs_s  = S_ARVALID & S_ARREADY;
  assign r_hs_s   = (rd_state_r == R_DATA) & S_RVALID & S_RREADY;
  assign aw_hs_s  = S_AWVALID & S_AWREADY;
  assign w_hs_s   = S_WVALID & S_WREADY;
  assign b_hs_s   = (wr_state_r == W_RESP) & S_BVALID & S_BREADY;
  assign RD_GNT   = rd_gnt_r;
  assign WR_GNT   = wr_gnt_r;

  // Read arbiter FSM: latch owner on grant, hold it until the R handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state_r <= R_IDLE;
      rd_owner_r <= 1'b0;
      rd_last_r  <= 1'b1;
      rd_gnt_r   <= 2'b00;
    end else begin
      case (rd_state_r)
        R_IDLE: if (rd_req_s != 2'b00) begin
          rd_owner_r <= pick_owner(rd_req_s, rd_last_r);
          rd_gnt_r   <= onehot(pick_owner(rd_req_s, rd_last_r));
          rd_state_r <= R_ADDR;
        end
        R_ADDR: if (ar_hs_s) rd_state_r <= R_DATA;
        R_DATA: if (r_hs_s) begin
          rd_last_r  <= rd_owner_r;
          rd_gnt_r   <= 2'b00;
          rd_state_r <= R_IDLE;
        end
        default: begin
          rd_gnt_r   <= 2'b00;
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write arbiter FSM: AW and W complete independently, then wait for B.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_r <= W_IDLE;
      wr_owner_r <= 1'b0;
      wr_last_r  <= 1'b1;
      wr_gnt_r   <= 2'b00;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: if (wr_req_s != 2'b00) begin
          wr_owner_r <= pick_owner(wr_req_s, wr_last_r);
          wr_gnt_r   <= onehot(pick_owner(wr_req_s, wr_last_r));
          aw_done_r  <= 1'b0;
          w_done_r   <= 1'b0;
          wr_state_r <= W_XFER;
        end
        W_XFER: begin
          aw_done_r <= aw_done_r | aw_hs_s;
          w_done_r  <= w_done_r | w_hs_s;
          if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) wr_state_r <= W_RESP;
        end
        W_RESP: if (b_hs_s) begin
          wr_last_r  <= wr_owner_r;
          wr_gnt_r   <= 2'b00;
          wr_state_r <= W_IDLE;
        end
        default: begin
          wr_gnt_r   <= 2'b00;
          wr_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read path routing: only the owner sees the slave; everything else is zero.
  always_comb begin
    S_ARADDR = {AXI_AWIDTH{1'b0}}; S_ARPROT = 3'b000; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    M0_ARREADY = 1'b0; M0_RDATA = {AXI_DWIDTH{1'b0}}; M0_RRESP = 2'b00; M0_RVALID = 1'b0;
    M1_ARREADY = 1'b0; M1_RDATA = {AXI_DWIDTH{1'b0}}; M1_RRESP = 2'b00; M1_RVALID = 1'b0;
    if (rd_state_r == R_ADDR) begin
      if (rd_owner_r) begin
        S_ARADDR = M1_ARADDR; S_ARPROT = M1_ARPROT; S_ARVALID = M1_ARVALID; M1_ARREADY = S_ARREADY;
      end else begin
        S_ARADDR = M0_ARADDR; S_ARPROT = M0_ARPROT; S_ARVALID = M0_ARVALID; M0_ARREADY = S_ARREADY;
      end
    end else if (rd_state_r == R_DATA) begin
      if (rd_owner_r) begin
        M1_RDATA = S_RDATA; M1_RRESP = S_RRESP; M1_RVALID = S_RVALID; S_RREADY = M1_RREADY;
      end else begin
        M0_RDATA = S_RDATA; M0_RRESP = S_RRESP; M0_RVALID = S_RVALID; S_RREADY = M0_RREADY;
      end
    end else begin
      S_ARVALID = 1'b0;
    end
  end

  // Write path routing: a finished AW or W channel is masked so it cannot repeat.
  always_comb begin
    S_AWADDR = {AXI_AWIDTH{1'b0}}; S_AWPROT = 3'b000; S_AWVALID = 1'b0;
    S_WDATA = {AXI_DWIDTH{1'b0}}; S_WSTRB = {(AXI_DWIDTH/8){1'b0}}; S_WVALID = 1'b0; S_BREADY = 1'b0;
    M0_AWREADY = 1'b0; M0_WREADY = 1'b0; M0_BRESP = 2'b00; M0_BVALID = 1'b0;
    M1_AWREADY = 1'b0; M1_WREADY = 1'b0; M1_BRESP = 2'b00; M1_BVALID = 1'b0;
    if (wr_state_r == W_XFER) begin
      if (wr_owner_r) begin
        S_AWADDR = M1_AWADDR; S_AWPROT = M1_AWPROT; S_AWVALID = M1_AWVALID & ~aw_done_r;
        S_WDATA = M1_WDATA; S_WSTRB = M1_WSTRB; S_WVALID = M1_WVALID & ~w_done_r;
        M1_AWREADY = S_AWREADY & ~aw_done_r; M1_WREADY = S_WREADY & ~w_done_r;
      end else begin
        S_AWADDR = M0_AWADDR; S_AWPROT = M0_AWPROT; S_AWVALID = M0_AWVALID & ~aw_done_r;
        S_WDATA = M0_WDATA; S_WSTRB = M0_WSTRB; S_WVALID = M0_WVALID & ~w_done_r;
        M0_AWREADY = S_AWREADY & ~aw_done_r; M0_WREADY = S_WREADY & ~w_done_r;
      end
    end else if (wr_state_r == W_RESP) begin
      if (wr_owner_r) begin
        M1_BRESP = S_BRESP; M1_BVALID = S_BVALID; S_BREADY = M1_BREADY;
      end else begin
        M0_BRESP = S_BRESP; M0_BVALID = S_BVALID; S_BREADY = M0_BREADY;
      end
    end else begin
      S_AWVALID = 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed testbench for axil_arbiter_2to1: the bench plays both masters and the
// slave cycle by cycle. Inputs change 1 ns after the rising edge, outputs are
// sampled on the falling edge.
module tb_axil_arbiter_2to1;

  logic        ACLK, ARESETN;
  logic [31:0] M0_AWADDR, M1_AWADDR, M0_ARADDR, M1_ARADDR, M0_WDATA, M1_WDATA;
  logic [2:0]  M0_AWPROT, M1_AWPROT, M0_ARPROT, M1_ARPROT;
  logic [3:0]  M0_WSTRB, M1_WSTRB;
  logic        M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID, M0_BREADY, M1_BREADY;
  logic        M0_ARVALID, M1_ARVALID, M0_RREADY, M1_RREADY;
  logic        M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY, M0_BVALID, M1_BVALID;
  logic        M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID;
  logic [1:0]  M0_BRESP, M1_BRESP, M0_RRESP, M1_RRESP;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
  logic [2:0]  S_AWPROT, S_ARPROT;
  logic [3:0]  S_WSTRB;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [1:0]  S_BRESP, S_RRESP, RD_GNT, WR_GNT;
  logic        all_vr_s;

  int checks = 0;
  int failures = 0;
  int aw_n, w_n, m0_n, waited;

  axil_arbiter_2to1 #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M0_AWADDR(M0_AWADDR), .M0_AWPROT(M0_AWPROT), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M0_ARADDR(M0_ARADDR), .M0_ARPROT(M0_ARPROT), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWPROT(M1_AWPROT), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARPROT(M1_ARPROT), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .RD_GNT(RD_GNT), .WR_GNT(WR_GNT)
  );

  assign all_vr_s = M0_AWREADY | M0_WREADY | M0_BVALID | M0_ARREADY | M0_RVALID |
                    M1_AWREADY | M1_WREADY | M1_BVALID | M1_ARREADY | M1_RVALID |
                    S_AWVALID | S_WVALID | S_BREADY | S_ARVALID | S_RREADY;

  // free-running clock, rising edges at 5, 15, 25 ...
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic sample();
    @(negedge ACLK);
  endtask

  task automatic clear_inputs();
    M0_AWADDR = 32'h0; M0_AWPROT = 3'b000; M0_AWVALID = 1'b0; M0_WDATA = 32'h0; M0_WSTRB = 4'h0;
    M0_WVALID = 1'b0; M0_BREADY = 1'b0; M0_ARADDR = 32'h0; M0_ARPROT = 3'b000; M0_ARVALID = 1'b0;
    M0_RREADY = 1'b0;
    M1_AWADDR = 32'h0; M1_AWPROT = 3'b000; M1_AWVALID = 1'b0; M1_WDATA = 32'h0; M1_WSTRB = 4'h0;
    M1_WVALID = 1'b0; M1_BREADY = 1'b0; M1_ARADDR = 32'h0; M1_ARPROT = 3'b000; M1_ARVALID = 1'b0;
    M1_RREADY = 1'b0;
    S_AWREADY = 1'b0; S_WREADY = 1'b0; S_BRESP = 2'b00; S_BVALID = 1'b0; S_ARREADY = 1'b0;
    S_RDATA = 32'h0; S_RRESP = 2'b00; S_RVALID = 1'b0;
  endtask

  task automatic do_reset();
    step(); ARESETN = 1'b0;
    step();
    step(); ARESETN = 1'b1;
    sample();
  endtask

  task automatic count_w();
    if (S_AWVALID && S_AWREADY) aw_n++;
    if (S_WVALID && S_WREADY) w_n++;
    if (M0_AWREADY || M0_WREADY || M0_BVALID) m0_n++;
  endtask

  initial begin
    clear_inputs();
    ARESETN = 1'b0;

    // reset state
    step(); step(); sample();
    check_eq("rst_rd_gnt", RD_GNT, 2'b00);
    check_eq("rst_wr_gnt", WR_GNT, 2'b00);
    check_eq("rst_valid_ready", all_vr_s, 1'b0);

    // single read by M0
    step(); ARESETN = 1'b1; M0_ARVALID = 1'b1; M0_ARADDR = 32'h0000_0010; S_ARREADY = 1'b1;
    sample();
    check_eq("rd1_idle_arvalid", S_ARVALID, 1'b0);
    step(); sample();
    check_eq("rd1_s_arvalid", S_ARVALID, 1'b1);
    check_eq("rd1_s_araddr", S_ARADDR, 32'h0000_0010);
    check_eq("rd1_rd_gnt", RD_GNT, 2'b01);
    check_eq("rd1_m0_arready", M0_ARREADY, 1'b1);
    check_eq("rd1_m1_arready", M1_ARREADY, 1'b0);
    step(); M0_ARVALID = 1'b0; M0_ARADDR = 32'h0; S_RVALID = 1'b1; S_RDATA = 32'hDEAD_BEEF; M0_RREADY = 1'b1;
    sample();
    check_eq("rd1_m0_rvalid", M0_RVALID, 1'b1);
    check_eq("rd1_m0_rdata", M0_RDATA, 32'hDEAD_BEEF);
    check_eq("rd1_m1_rvalid", M1_RVALID, 1'b0);
    check_eq("rd1_s_rready", S_RREADY, 1'b1);
    step(); clear_inputs(); sample();
    check_eq("rd1_gnt_release", RD_GNT, 2'b00);

    // read contention from reset: grants alternate M0, M1, M0, M1
    M0_ARVALID = 1'b1; M0_ARADDR = 32'h0000_0100; M1_ARVALID = 1'b1; M1_ARADDR = 32'h0000_0200;
    M0_RREADY = 1'b1; M1_RREADY = 1'b1; S_ARREADY = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      do begin
        step(); sample(); waited++;
      end while (S_ARVALID !== 1'b1 && waited < 8);
      check_eq("ctn_wait", waited, 1);
      check_eq("ctn_rd_gnt", RD_GNT, (i % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("ctn_s_araddr", S_ARADDR, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      step(); M0_ARVALID = 1'b0; M1_ARVALID = 1'b0; S_RVALID = 1'b1;
      S_RDATA = (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      sample();
      if (i % 2 == 0) begin
        check_eq("ctn_m0_rdata", M0_RDATA, 32'h1111_1111);
        check_eq("ctn_m1_rvalid", M1_RVALID, 1'b0);
      end else begin
        check_eq("ctn_m1_rdata", M1_RDATA, 32'h2222_2222);
        check_eq("ctn_m0_rvalid", M0_RVALID, 1'b0);
      end
      step(); S_RVALID = 1'b0;
      if (i < 3) begin M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; end
      sample();
    end
    clear_inputs();

    // M1 write, W two cycles before AW; W held high to exercise masking
    aw_n = 0; w_n = 0; m0_n = 0;
    step(); S_AWREADY = 1'b1; S_WREADY = 1'b1; M1_WVALID = 1'b1; M1_WDATA = 32'hA5A5_A5A5; M1_WSTRB = 4'hF;
    sample(); count_w();
    check_eq("wr_idle_gnt", WR_GNT, 2'b00);
    step(); sample(); count_w();
    check_eq("wr_gnt_m1", WR_GNT, 2'b10);
    check_eq("wr_s_wvalid", S_WVALID, 1'b1);
    check_eq("wr_s_wdata", S_WDATA, 32'hA5A5_A5A5);
    check_eq("wr_s_wstrb", S_WSTRB, 4'hF);
    check_eq("wr_s_awvalid_early", S_AWVALID, 1'b0);
    step(); M1_AWVALID = 1'b1; M1_AWADDR = 32'h4000_0004;
    sample(); count_w();
    check_eq("wr_s_awvalid", S_AWVALID, 1'b1);
    check_eq("wr_s_awaddr", S_AWADDR, 32'h4000_0004);
    check_eq("wr_w_masked", S_WVALID, 1'b0);
    check_eq("wr_m1_wready_masked", M1_WREADY, 1'b0);
    step(); S_BVALID = 1'b1; S_BRESP = 2'b00; M1_BREADY = 1'b1;
    sample(); count_w();
    check_eq("wr_m1_bvalid", M1_BVALID, 1'b1);
    check_eq("wr_m1_bresp", M1_BRESP, 2'b00);
    check_eq("wr_s_bready", S_BREADY, 1'b1);
    step(); clear_inputs(); sample(); count_w();
    check_eq("wr_gnt_release", WR_GNT, 2'b00);
    check_eq("wr_aw_hs_count", aw_n, 1);
    check_eq("wr_w_hs_count", w_n, 1);
    check_eq("wr_m0_activity", m0_n, 0);

    // concurrent M0 read and M1 write
    step(); M0_ARVALID = 1'b1; M0_ARADDR = 32'h0000_0020; S_ARREADY = 1'b1;
    M1_AWVALID = 1'b1; M1_AWADDR = 32'h0000_0030; M1_WVALID = 1'b1; M1_WDATA = 32'h1234_5678;
    M1_WSTRB = 4'h3; S_AWREADY = 1'b1; S_WREADY = 1'b1;
    sample();
    step(); sample();
    check_eq("cc_rd_gnt", RD_GNT, 2'b01);
    check_eq("cc_wr_gnt", WR_GNT, 2'b10);
    check_eq("cc_s_arvalid", S_ARVALID, 1'b1);
    check_eq("cc_s_awvalid", S_AWVALID, 1'b1);
    check_eq("cc_s_wvalid", S_WVALID, 1'b1);
    check_eq("cc_s_wstrb", S_WSTRB, 4'h3);
    step(); M0_ARVALID = 1'b0; M1_AWVALID = 1'b0; M1_WVALID = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 32'hCAFE_F00D; M0_RREADY = 1'b1;
    S_BVALID = 1'b1; S_BRESP = 2'b10; M1_BREADY = 1'b1;
    sample();
    check_eq("cc_m0_rvalid", M0_RVALID, 1'b1);
    check_eq("cc_m0_rdata", M0_RDATA, 32'hCAFE_F00D);
    check_eq("cc_m1_bvalid", M1_BVALID, 1'b1);
    check_eq("cc_m1_bresp", M1_BRESP, 2'b10);
    check_eq("cc_m0_bvalid", M0_BVALID, 1'b0);
    check_eq("cc_m1_rvalid", M1_RVALID, 1'b0);
    step(); clear_inputs(); sample();
    check_eq("cc_rd_release", RD_GNT, 2'b00);
    check_eq("cc_wr_release", WR_GNT, 2'b00);

    // backpressure: ARREADY low 5 cycles, RREADY low 3 cycles, M1 waiting
    step(); M0_ARVALID = 1'b1; M0_ARADDR = 32'h0000_0044;
    sample();
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) begin M1_ARVALID = 1'b1; M1_ARADDR = 32'h0000_0088; end
      sample();
      check_eq("bp_s_arvalid", S_ARVALID, 1'b1);
      check_eq("bp_s_araddr", S_ARADDR, 32'h0000_0044);
      check_eq("bp_rd_gnt", RD_GNT, 2'b01);
      check_eq("bp_m1_arready", M1_ARREADY, 1'b0);
    end
    step(); S_ARREADY = 1'b1; sample();
    check_eq("bp_m0_arready", M0_ARREADY, 1'b1);
    check_eq("bp_m1_arready_hs", M1_ARREADY, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step();
      if (j == 0) begin M0_ARVALID = 1'b0; S_RVALID = 1'b1; S_RDATA = 32'h5555_AAAA; end
      sample();
      check_eq("bp_s_rready_low", S_RREADY, 1'b0);
      check_eq("bp_m0_rvalid", M0_RVALID, 1'b1);
      check_eq("bp_rd_gnt_hold", RD_GNT, 2'b01);
      check_eq("bp_m1_arready_wait", M1_ARREADY, 1'b0);
    end
    step(); M0_RREADY = 1'b1; sample();
    check_eq("bp_s_rready", S_RREADY, 1'b1);
    check_eq("bp_m0_rdata", M0_RDATA, 32'h5555_AAAA);
    step(); S_RVALID = 1'b0; M0_RREADY = 1'b0; sample();
    check_eq("bp_idle_gnt", RD_GNT, 2'b00);
    check_eq("bp_idle_m1_arready", M1_ARREADY, 1'b0);
    step(); sample();
    check_eq("bp_m1_gnt", RD_GNT, 2'b10);
    check_eq("bp_m1_araddr", S_ARADDR, 32'h0000_0088);
    check_eq("bp_m1_arready_go", M1_ARREADY, 1'b1);
    step(); M1_ARVALID = 1'b0; S_RVALID = 1'b1; S_RDATA = 32'h8888_8888; M1_RREADY = 1'b1;
    sample();
    check_eq("bp_m1_rdata", M1_RDATA, 32'h8888_8888);
    step(); clear_inputs(); sample();
    check_eq("bp_release", RD_GNT, 2'b00);

    // reset asserted while M1 write sits in the response phase
    step(); M1_AWVALID = 1'b1; M1_WVALID = 1'b1; M1_AWADDR = 32'h0000_0050; M1_WDATA = 32'h0BAD_F00D;
    M1_WSTRB = 4'hF; S_AWREADY = 1'b1; S_WREADY = 1'b1;
    sample();
    step(); sample();
    check_eq("mr_gnt_m1", WR_GNT, 2'b10);
    step(); M1_AWVALID = 1'b0; M1_WVALID = 1'b0; M1_BREADY = 1'b1;
    sample();
    check_eq("mr_in_resp", S_BREADY, 1'b1);
    check_eq("mr_aw_quiet", S_AWVALID, 1'b0);
    step(); ARESETN = 1'b0; S_BVALID = 1'b1;
    sample();
    step(); ARESETN = 1'b1;
    sample();
    check_eq("mr_wr_gnt", WR_GNT, 2'b00);
    check_eq("mr_valid_ready", all_vr_s, 1'b0);
    step(); S_BVALID = 1'b0; M1_BREADY = 1'b0;
    M0_AWVALID = 1'b1; M0_WVALID = 1'b1; M0_AWADDR = 32'h0000_0060; M0_WDATA = 32'h600D_600D; M0_WSTRB = 4'hF;
    M1_AWVALID = 1'b1; M1_WVALID = 1'b1; M1_AWADDR = 32'h0000_0070;
    sample();
    check_eq("mr_pre_gnt", WR_GNT, 2'b00);
    step(); sample();
    check_eq("mr_tie_m0", WR_GNT, 2'b01);
    check_eq("mr_s_awaddr", S_AWADDR, 32'h0000_0060);
    check_eq("mr_m0_awready", M0_AWREADY, 1'b1);
    check_eq("mr_m1_awready", M1_AWREADY, 1'b0);
    step(); M0_AWVALID = 1'b0; M0_WVALID = 1'b0; S_BVALID = 1'b1; M0_BREADY = 1'b1;
    sample();
    check_eq("mr_m0_bvalid", M0_BVALID, 1'b1);
    check_eq("mr_m1_bvalid", M1_BVALID, 1'b0);
    step(); S_BVALID = 1'b0; M0_BREADY = 1'b0; sample();
    check_eq("mr_idle_gap", WR_GNT, 2'b00);
    step(); sample();
    check_eq("mr_next_m1", WR_GNT, 2'b10);
    step(); M1_AWVALID = 1'b0; M1_WVALID = 1'b0; S_BVALID = 1'b1; M1_BREADY = 1'b1;
    sample();
    check_eq("mr_m1_bvalid_done", M1_BVALID, 1'b1);
    step(); clear_inputs(); sample();
    check_eq("mr_final_gnt", WR_GNT, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_2to1.md
# axil_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter that shares the core's downstream bus port between the instruction-fetch master (M0) and the data/host master (M1). It replaces per-cycle master muxing with transaction-locked arbitration. Read and write paths have independent round-robin arbiters, so a fetch and a store may run concurrently. Its slave port (S) feeds the address-decoding bus interconnect.

## Interface
- AXI_AWIDTH, default 32: address width.
- AXI_DWIDTH, default 32: data width. Strobe width is AXI_DWIDTH/8.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset. Synchronous, active-low; clock ACLK.
- Mx_AWADDR/AWPROT/AWVALID  in  AWIDTH/3/1  (x=0,1) write address request. Mx_AWREADY  out  1.
- Mx_WDATA/WSTRB/WVALID  in  DWIDTH/DWIDTH/8/1  write data. Mx_WREADY  out  1.
- Mx_BRESP/BVALID  out  2/1  write response. Mx_BREADY  in  1.
- Mx_ARADDR/ARPROT/ARVALID  in  AWIDTH/3/1  read address. Mx_ARREADY  out  1.
- Mx_RDATA/RRESP/RVALID  out  DWIDTH/2/1  read data. Mx_RREADY  in  1.
- S_AW*, S_W*, S_B*, S_AR*, S_R*: mirror set toward the slave. Directions are reversed, with the same widths.
- RD_GNT  out  2  one-hot read owner. 00 means idle.
- WR_GNT  out  2  one-hot write owner. 00 means idle.

## Operation
Read FSM, states R_IDLE, R_ADDR and R_DATA:
- **R_IDLE:** if any Mx_ARVALID is high, register the owner and go to R_ADDR.
  - If only one master requests, that master wins.
  - If both request, the master that is not rd_last wins.
- **R_ADDR:** forward the owner's AR channel to S. The S_ARREADY handshake moves the FSM to R_DATA.
- **R_DATA:** route S_RDATA, S_RRESP and S_RVALID to the owner, and route the owner's RREADY to S_RREADY. On the RVALID & RREADY handshake:
  - set rd_last to the owner,
  - clear the owner,
  - return to R_IDLE.

Write FSM, states W_IDLE, W_XFER and W_RESP:
- **W_IDLE:** a request is Mx_AWVALID | Mx_WVALID. Grant the owner the same way as reads, using wr_last, then go to W_XFER and clear the aw_done and w_done flags.
- **W_XFER:** forward the owner's AW and W channels to S independently.
  - Gate a channel's S_xVALID to 0 once its done flag is set.
  - Set each flag on its handshake.
  - When both flags are set, go to W_RESP. This includes the case where both handshakes happen in the same cycle.
- **W_RESP:** route the B channel to the owner. On the BVALID & BREADY handshake:
  - set wr_last to the owner,
  - go to W_IDLE.

Rules that apply to both paths:
- A non-owner always sees READY=0 and VALID=0.
- When a path is idle, S-side VALIDs are 0, and S-side addr/data/prot/strb are 0.
- Only one outstanding transaction per direction. The owner never changes mid-transaction.

## Timing
- **Reset:** all FSMs go idle and every output VALID/READY is 0. RD_GNT and WR_GNT are 00. rd_last and wr_last are set to M1, so M0 wins the first tie.
- **Reset mid-transaction:** the arbiter abandons the transaction with no response. The slave is assumed to be reset by the same ARESETN.
- **Grant latency:** 1 cycle. A request seen in cycle N drives S_xVALID in cycle N+1.
- **Handshake pass-through:** READY/VALID pass combinationally between the owner and S. No data is buffered.
- **Read round trip:** 2 cycles plus slave latency when the slave is zero-wait. Example: ARVALID at N, S_ARVALID and S_ARREADY at N+1, RVALID at N+2 or later.
- **Back-to-back:** after a completed transaction, the FSM spends 1 idle cycle before the next grant.
- **Fairness:** under continuous contention, grants alternate M0, M1, M0, ... Worst-case wait is one transaction.
- **Concurrency:** the read and write paths never stall each other.

## Test plan
- **Single read:** M0 reads 0x0000_0010 and the slave returns 0xDEADBEEF.
  - Expect S_ARVALID at cycle 1 and RD_GNT=01.
  - Expect M0_RDATA=0xDEADBEEF while M1_RVALID stays 0.
- **Read contention:** both masters hold ARVALID from reset.
  - Expect grant order M0, M1, M0, M1 over 4 reads.
  - Each master receives only its own data (M0→0x11111111, M1→0x22222222).
- **Write with W before AW:** M1 asserts WVALID (0xA5A5A5A5, strb F) 2 cycles before AWVALID (0x4000_0004).
  - Expect exactly one S_WVALID handshake and one S_AWVALID handshake.
  - Expect M1_BVALID with BRESP=00, and no M0 activity.
- **Concurrent read and write:** M0 reads while M1 writes, starting in the same cycle.
  - Both complete with no added latency, and RD_GNT=01 and WR_GNT=10 simultaneously.
- **Backpressure:** slave holds ARREADY=0 for 5 cycles and M0 holds RREADY=0 for 3 cycles.
  - S_ARADDR stays stable and the owner is unchanged.
  - M1's pending AR stays unacknowledged until M0's R handshake completes.
- **Reset mid-write:** deassert ARESETN during W_RESP.
  - Next cycle: WR_GNT=00 and all S/M VALID/READY outputs are 0.
  - The next write from M0 wins the first tie.
